mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port memory bus between instruction fetch (IF) and load/store (LS) requesters in the rvseed core.
- Arbitrates between the two sources and sequences each transfer through a request/grant/response handshake.
- Aborts hung transfers with a timeout.
- Generates the pipeline stall that gates the core's pc/ena path while a transfer is outstanding.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, maximum cycles from mem_req assertion to mem_rvalid before abort (1..255)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request, held until if_rvalid
if_addr  input  AW  fetch address
if_rdata  output  DW  fetch data
if_rvalid  output  1  fetch complete, 1-cycle pulse
ls_req  input  1  load/store request, held until ls_rvalid
ls_we  input  1  1 = store
ls_addr  input  AW  load/store address
ls_wdata  input  DW  store data
ls_wstrb  input  DW/8  store byte strobes
ls_rdata  output  DW  load data
ls_rvalid  output  1  load/store complete, 1-cycle pulse
bus_err  output  1  qualifies the current if_rvalid/ls_rvalid as a timeout abort
mem_req  output  1  memory request
mem_we  output  1  memory write
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_wstrb  output  DW/8  memory strobes
mem_gnt  input  1  memory accepted request
mem_rvalid  input  1  memory response (reads and writes)
mem_rdata  input  DW  memory read data
stall  output  1  hold core pc/ena

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; owner = IF; prio = LS.
  - Timeout counter = 0.
  - All mem_* outputs = 0; if_rvalid, ls_rvalid, bus_err = 0.
- Mid-transfer reset: mem_req drops immediately; the in-flight transfer is discarded with no rvalid.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - If exactly one request is asserted, that source wins.
  - If both are asserted, the source named by prio wins.
  - On the winning cycle: latch owner, addr, we, wdata and wstrb into registers; prio flips to the non-winner; go to REQ.
  - For IF the latched we = 0 and wstrb = 0.
- REQ:
  - mem_req = 1; mem_we/addr/wdata/wstrb are driven from the latched registers and stay stable until grant.
  - mem_gnt = 1 -> WAIT; mem_req is 0 from the next cycle.
- WAIT:
  - mem_rvalid = 1 -> owner's rvalid = 1 in that same cycle (combinational pass-through); owner's rdata = mem_rdata; go to IDLE.
  - The non-owner's rvalid stays 0 and its rdata is 0.
- Response timing rules:
  - mem_rvalid in the same cycle as mem_gnt is ignored; the memory returns it no earlier than the cycle after grant.
  - mem_rvalid outside WAIT is ignored.
- Single outstanding transfer: there is always one IDLE bubble between transfers. Requests arriving during REQ/WAIT are held by the requester and arbitrated in IDLE.
- Timeout counter:
  - Cleared on entry to REQ; increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT-1 without completion: owner's rvalid = 1, bus_err = 1, owner's rdata = 0, mem_req forced 0, go to IDLE.
  - If mem_rvalid arrives in the same cycle as expiry, the normal completion wins and bus_err = 0.
- stall = (if_req & ~if_rvalid) | (ls_req & ~ls_rvalid). Combinational; 0 in the completion cycle of the last pending request.
- Stores: completion is signalled by ls_rvalid; ls_rdata is don't-care and driven as mem_rdata.
- Requester rule: each requester keeps its req/addr/data stable from assertion to its rvalid. The arbiter does not re-sample a request after it has been latched.

Decomposition:
- Add to rvseed_defines.v:
  - Arbiter state encodings: `ARB_IDLE`, `ARB_REQ`, `ARB_WAIT` (2-bit).
  - Owner encodings: `ARB_OWN_IF` = 0, `ARB_OWN_LS` = 1.
  - `ARB_TO_WIDTH` = 8.
- Sub-module mem_arb_rr: combinational 2-way round-robin pick.
  - Inputs: if_req, ls_req, prio.
  - Outputs: grant_valid, grant_owner.
- The top holds the FSM, the latch registers, the timeout counter and the response steering.

Test Plan:
- Single read: if_req with if_addr=0x100, gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> mem_addr=0x100, mem_we=0, if_rvalid pulses once with if_rdata=0xDEADBEEF, stall low that cycle, bus_err=0.
- Contention after reset: if_req and ls_req raised together, ls_we=1, ls_addr=0x200, ls_wdata=0x12345678, ls_wstrb=0xF -> LS is served first with matching mem_* values; IF is served next after one IDLE bubble.
- Round-robin: both requesters held high for 4 transfers -> grant order LS, IF, LS, IF.
- Timeout: mem_gnt given but mem_rvalid never returns, TIMEOUT=16 -> the owner's rvalid and bus_err pulse together 16 cycles after REQ entry, rdata=0, FSM returns to IDLE and the next request proceeds normally.
- Same-cycle gnt+rvalid: mem_rvalid is asserted with mem_gnt, then again 1 cycle later with 0xA5A5A5A5 -> the first is ignored, a single rvalid is delivered with 0xA5A5A5A5.
- Reset during WAIT: rst_n pulsed low mid-transfer -> mem_req=0 and no rvalid; afterwards prio=LS and a new ls_req is granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/LS memory bus arbiter: FSM states, owner encoding, timeout width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnLs = 1'b1
  } arb_owner_e;

  localparam int unsigned ArbToWidth = 8;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin pick between fetch and load/store requests.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       ls_req,
  input  arb_owner_e prio,
  output logic       grant_valid,
  output arb_owner_e grant_owner
);

  always_comb begin
    grant_valid = if_req | ls_req;
    grant_owner = OwnIf;
    if (if_req && ls_req) begin
      grant_owner = prio;
    end else if (ls_req) begin
      grant_owner = OwnLs;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between fetch and load/store, one transfer at a time,
// with a timeout abort and the core stall.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_rvalid,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wstrb,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_rvalid,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall
);

  localparam logic [ArbToWidth-1:0] ToLast = ArbToWidth'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  arb_owner_e            prio_q, prio_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW/8-1:0]       wstrb_q, wstrb_d;
  logic [ArbToWidth-1:0] cnt_q, cnt_d;

  logic       grant_valid;
  arb_owner_e grant_owner;
  logic       complete, expire, done;

  mem_arb_rr u_rr (
    .if_req      (if_req),
    .ls_req      (ls_req),
    .prio        (prio_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // A response in the grant cycle lands in REQ and is ignored; only WAIT accepts it.
  assign complete = (state_q == StWait) && mem_rvalid;
  assign expire   = (state_q != StIdle) && (cnt_q == ToLast) && !complete;
  assign done     = complete | expire;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StReq;
          owner_d = grant_owner;
          prio_d  = (grant_owner == OwnIf) ? OwnLs : OwnIf;
          cnt_d   = '0;
          if (grant_owner == OwnLs) begin
            addr_d  = ls_addr;
            we_d    = ls_we;
            wdata_d = ls_wdata;
            wstrb_d = ls_wstrb;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (expire) begin
          state_d = StIdle;
        end else if (mem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
      prio_q  <= OwnLs;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = (state_q == StReq) && !expire;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  assign if_rvalid = done && (owner_q == OwnIf);
  assign ls_rvalid = done && (owner_q == OwnLs);
  assign bus_err   = expire;
  assign if_rdata  = (complete && (owner_q == OwnIf)) ? mem_rdata : '0;
  assign ls_rdata  = (complete && (owner_q == OwnLs)) ? mem_rdata : '0;

  assign stall = (if_req & ~if_rvalid) | (ls_req & ~ls_rvalid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: random requesters and memory slave against a
// transaction-level model of the arbitration, timeout and response rules.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_rvalid;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [3:0]    ls_wstrb = '0;
  logic [DW-1:0] ls_rdata;
  logic          ls_rvalid;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall;

  mem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_rvalid  (if_rvalid),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_wstrb   (ls_wstrb),
    .ls_rdata   (ls_rdata),
    .ls_rvalid  (ls_rvalid),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Requester-side held transactions.
  bit          if_pend = 0;
  logic [31:0] if_a = '0;
  bit          ls_pend = 0;
  bit          ls_w = 0;
  logic [31:0] ls_a = '0;
  logic [31:0] ls_d = '0;
  logic [3:0]  ls_s = '0;

  // Reference model: one transfer in flight at most, plus who goes first on a tie.
  bit m_busy = 0;
  bit m_own = 0;      // 0 = fetch, 1 = load/store
  bit m_prio = 1;
  bit m_granted = 0;
  int m_age = 0;      // cycles since the transfer started requesting
  bit hang_gnt = 0;
  bit hang_rsp = 0;
  int n_timeouts = 0;
  int n_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit force_both);
    bit          e_done, e_to, e_req, e_ifv, e_lsv, e_stall;
    logic [31:0] e_ifd, e_lsd;
    @(posedge clk);
    #1;
    if (!if_pend && (force_both || $urandom_range(3) == 0)) begin
      if_pend = 1;
      if_a    = $urandom;
    end
    if (!ls_pend && (force_both || $urandom_range(3) == 0)) begin
      ls_pend = 1;
      ls_w    = 1'($urandom_range(1));
      ls_a    = $urandom;
      ls_d    = $urandom;
      ls_s    = 4'($urandom);
    end
    if_req     = if_pend;
    if_addr    = if_pend ? if_a : $urandom;
    ls_req     = ls_pend;
    ls_we      = ls_pend ? ls_w : 1'($urandom_range(1));
    ls_addr    = ls_pend ? ls_a : $urandom;
    ls_wdata   = ls_pend ? ls_d : $urandom;
    ls_wstrb   = ls_pend ? ls_s : 4'($urandom);
    mem_gnt    = !hang_gnt && ($urandom_range(9) < 4);
    mem_rvalid = !hang_rsp && ($urandom_range(9) < 3);
    mem_rdata  = $urandom;
    @(negedge clk);

    // A response counts only after the grant cycle; completion beats expiry.
    e_done  = m_busy && m_granted && mem_rvalid;
    e_to    = m_busy && !e_done && (m_age == TO - 1);
    e_req   = m_busy && !m_granted && !e_to;
    e_ifv   = (e_done || e_to) && !m_own;
    e_lsv   = (e_done || e_to) && m_own;
    e_ifd   = (e_done && !m_own) ? mem_rdata : 32'h0;
    e_lsd   = (e_done && m_own) ? mem_rdata : 32'h0;
    e_stall = (if_req && !e_ifv) || (ls_req && !e_lsv);

    check_eq("mem_req", 64'(mem_req), 64'(e_req));
    check_eq("if_rvalid", 64'(if_rvalid), 64'(e_ifv));
    check_eq("ls_rvalid", 64'(ls_rvalid), 64'(e_lsv));
    check_eq("bus_err", 64'(bus_err), 64'(e_to));
    check_eq("if_rdata", 64'(if_rdata), 64'(e_ifd));
    check_eq("ls_rdata", 64'(ls_rdata), 64'(e_lsd));
    check_eq("stall", 64'(stall), 64'(e_stall));
    if (e_req) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(m_own ? ls_a : if_a));
      check_eq("mem_we", 64'(mem_we), 64'(m_own ? ls_w : 1'b0));
      check_eq("mem_wdata", 64'(mem_wdata), 64'(m_own ? ls_d : 32'h0));
      check_eq("mem_wstrb", 64'(mem_wstrb), 64'(m_own ? ls_s : 4'h0));
    end

    if (m_busy) begin
      if (e_done || e_to) begin
        m_busy = 0;
        if (m_own) ls_pend = 0;
        else if_pend = 0;
        if (e_to) n_timeouts++;
        else n_done++;
      end else begin
        if (!m_granted && mem_gnt) m_granted = 1;
        m_age++;
      end
    end else if (if_pend || ls_pend) begin
      m_own     = (if_pend && ls_pend) ? m_prio : ls_pend;
      m_prio    = !m_own;
      m_busy    = 1;
      m_granted = 0;
      m_age     = 0;
      hang_gnt  = ($urandom_range(19) == 0);
      hang_rsp  = ($urandom_range(6) == 0);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_mem_req"}, 64'(mem_req), 64'h0);
    check_eq({tag, "_if_rvalid"}, 64'(if_rvalid), 64'h0);
    check_eq({tag, "_ls_rvalid"}, 64'(ls_rvalid), 64'h0);
    check_eq({tag, "_bus_err"}, 64'(bus_err), 64'h0);
    check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'h0);
    check_eq({tag, "_mem_we"}, 64'(mem_we), 64'h0);
  endtask

  // Async reset in the middle of a cycle; the transfer in flight must vanish.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #1;
    if_pend = 0;
    ls_pend = 0;
    if_req  = 1'b0;
    ls_req  = 1'b0;
    mem_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_quiet(tag);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    #1 check_quiet({tag, "_held"});
    mem_rvalid = 1'b0;
    m_busy   = 0;
    m_prio   = 1;
    hang_gnt = 0;
    hang_rsp = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input bit want_granted, input string tag);
    int n = 0;
    while (!(m_busy && (m_granted == want_granted) && (m_age < int'(TO) - 3)) && n < 300) begin
      step(0);
      n++;
    end
    check_eq({tag, "_reached"}, 64'(n < 300), 64'h1);
  endtask

  initial begin
    #2 check_quiet("reset");
    check_eq("reset_stall", 64'(stall), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters together straight after reset: load/store must win.
    step(1);
    repeat (1500) step(0);

    run_until(1'b0, "req_phase");
    mid_reset("rst_in_req");
    step(1);
    repeat (800) step(0);

    run_until(1'b1, "wait_phase");
    mid_reset("rst_in_wait");
    step(1);
    repeat (1500) step(0);

    check_eq("saw_timeouts", 64'(n_timeouts > 0), 64'h1);
    check_eq("saw_completions", 64'(n_done > 0), 64'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
